// File: rtl/lpif_tx_lane_striper_pkg.sv
// Shared encodings and configuration checks for the LPIF TX lane striper.
package lpif_tx_lane_striper_pkg;

   localparam logic [1:0] W_1B = 2'd0;
   localparam logic [1:0] W_2B = 2'd1;
   localparam logic [1:0] W_4B = 2'd2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef struct packed {
      logic [4:0] lanes;
      logic [2:0] wbytes;
   } stripe_cfg_t;

   function automatic logic [2:0] width_bytes(input logic [1:0] w);
      case (w)
         W_1B:    width_bytes = 3'd1;
         W_2B:    width_bytes = 3'd2;
         W_4B:    width_bytes = 3'd4;
         default: width_bytes = 3'd0;
      endcase
   endfunction

   function automatic logic lanes_legal(input logic [4:0] lanes, input int unsigned max_lanes);
      logic pow2;
      pow2 = (lanes != 5'd0) && ((lanes & (lanes - 5'd1)) == 5'd0);
      return pow2 && (32'(lanes) <= max_lanes);
   endfunction

   function automatic logic width_legal(input logic [1:0] w, input int unsigned max_width);
      return (w != 2'd3) && ((32'(width_bytes(w)) * 32'd8) <= max_width);
   endfunction

endpackage

// File: rtl/lpif_tx_lane_striper_if.sv
// LPIF transmit handshake plus per-lane PIPE TxData bundle.
interface lpif_tx_lane_striper_if #(
   parameter int unsigned LANESNUMBER  = 16,
   parameter int unsigned MAXPIPEWIDTH = 32,
   parameter int unsigned LPIF_BYTES   = 64
);
   logic                                  lp_irdy;
   logic [8*LPIF_BYTES-1:0]               lp_data;
   logic [LPIF_BYTES-1:0]                 lp_valid;
   logic                                  pl_trdy;
   logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   TxData;
   logic [LANESNUMBER-1:0]                TxDataValid;

   modport master (
      output lp_irdy, lp_data, lp_valid,
      input  pl_trdy, TxData, TxDataValid
   );

   modport slave (
      input  lp_irdy, lp_data, lp_valid,
      output pl_trdy, TxData, TxDataValid
   );
endinterface

// File: rtl/lpif_tx_lane_striper_ring.sv
// Byte-granular circular buffer with a multi-byte write port and a multi-byte peek/pop port.
module lpif_tx_lane_striper_ring #(
   parameter int unsigned BUF_BYTES = 256,
   parameter int unsigned WR_BYTES  = 64,
   parameter int unsigned RD_BYTES  = 64,
   localparam int unsigned PTR_W    = $clog2(BUF_BYTES),
   localparam int unsigned CNT_W    = $clog2(BUF_BYTES + 1),
   localparam int unsigned WN_W     = $clog2(WR_BYTES + 1),
   localparam int unsigned RN_W     = $clog2(RD_BYTES + 1)
) (
   input  logic                  i_pclk,
   input  logic                  i_reset_n,
   input  logic [WN_W-1:0]       i_wr_n,
   input  logic [8*WR_BYTES-1:0] i_wr_data,
   input  logic [RN_W-1:0]       i_rd_n,
   output logic [8*RD_BYTES-1:0] o_rd_data,
   output logic [CNT_W-1:0]      o_count
);

   logic [7:0]       r_mem [BUF_BYTES];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // Storage carries no reset; only the pointers and count define its contents.
   always_ff @(posedge i_pclk) begin
      for (int unsigned i = 0; i < WR_BYTES; i++) begin
         if (i < 32'(i_wr_n)) begin
            r_mem[r_wr_ptr + PTR_W'(i)] <= i_wr_data[8*i +: 8];
         end
      end
   end

   always_ff @(posedge i_pclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_wr_ptr <= r_wr_ptr + PTR_W'(i_wr_n);
         r_rd_ptr <= r_rd_ptr + PTR_W'(i_rd_n);
         r_count  <= r_count + CNT_W'(i_wr_n) - CNT_W'(i_rd_n);
      end
   end

   always_comb begin
      o_rd_data = '0;
      for (int unsigned i = 0; i < RD_BYTES; i++) begin
         o_rd_data[8*i +: 8] = r_mem[r_rd_ptr + PTR_W'(i)];
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/lpif_tx_lane_striper.sv
// Stripes buffered LPIF bytes across a runtime-selected lane count and PIPE width.
module lpif_tx_lane_striper
   import lpif_tx_lane_striper_pkg::*;
#(
   parameter int unsigned LANESNUMBER  = 16,
   parameter int unsigned MAXPIPEWIDTH = 32,
   parameter int unsigned LPIF_BYTES   = 64,
   parameter int unsigned BUF_BYTES    = 256,
   parameter logic [7:0]  PAD_BYTE     = 8'h00
) (
   input  logic                        i_pclk,
   input  logic                        i_reset_n,
   input  logic                        i_enable,
   input  logic [4:0]                  i_cfg_lanes,
   input  logic [1:0]                  i_cfg_width,
   lpif_tx_lane_striper_if.slave       io_bus,
   output logic                        o_busy,
   output logic                        o_err_cfg
);

   localparam int unsigned MAX_B  = LANESNUMBER * MAXPIPEWIDTH / 8;
   localparam int unsigned SLOTS  = MAXPIPEWIDTH / 8;
   localparam int unsigned CNT_W  = $clog2(BUF_BYTES + 1);
   localparam int unsigned PUSH_W = $clog2(LPIF_BYTES + 1);
   localparam int unsigned POP_W  = $clog2(MAX_B + 1);

   logic [1:0]                          r_state;
   logic [1:0]                          w_state_next;
   stripe_cfg_t                         r_cfg;
   logic                                r_err_cfg;
   logic [MAXPIPEWIDTH*LANESNUMBER-1:0] r_tx_data;
   logic [MAXPIPEWIDTH*LANESNUMBER-1:0] w_tx_data;
   logic [LANESNUMBER-1:0]              r_tx_valid;
   logic [LANESNUMBER-1:0]              w_lane_mask;
   logic                                w_cfg_ok;
   logic                                w_start;
   logic                                w_emit;
   logic [CNT_W-1:0]                    w_count;
   logic [PUSH_W-1:0]                   w_push_n;
   logic [POP_W-1:0]                    w_pop_n;
   logic [POP_W-1:0]                    w_b;
   logic [8*MAX_B-1:0]                  w_rd_data;
   logic [MAX_B-1:0][7:0]               w_pop_bytes;

   assign w_cfg_ok = lanes_legal(i_cfg_lanes, LANESNUMBER) && width_legal(i_cfg_width, MAXPIPEWIDTH);
   assign w_start  = (r_state == ST_IDLE) && i_enable && w_cfg_ok;

   assign io_bus.pl_trdy = (r_state == ST_RUN) && (w_count <= CNT_W'(BUF_BYTES - LPIF_BYTES));
   assign w_push_n = (io_bus.lp_irdy && io_bus.pl_trdy) ?
                     PUSH_W'($countones(io_bus.lp_valid)) : '0;

   lpif_tx_lane_striper_ring #(
      .BUF_BYTES (BUF_BYTES),
      .WR_BYTES  (LPIF_BYTES),
      .RD_BYTES  (MAX_B)
   ) u_ring (
      .i_pclk    (i_pclk),
      .i_reset_n (i_reset_n),
      .i_wr_n    (w_push_n),
      .i_wr_data (io_bus.lp_data),
      .i_rd_n    (w_pop_n),
      .o_rd_data (w_rd_data),
      .o_count   (w_count)
   );

   assign w_b         = POP_W'(32'(r_cfg.lanes) * 32'(r_cfg.wbytes));
   assign w_lane_mask = LANESNUMBER'((32'd1 << r_cfg.lanes) - 32'd1);

   // Pop size is decided from the pre-push count; a short tail is flushed only when no beat is
   // arriving to complete it.
   always_comb begin
      w_emit  = 1'b0;
      w_pop_n = '0;
      if (r_state != ST_IDLE) begin
         if (w_count >= CNT_W'(w_b)) begin
            w_emit  = 1'b1;
            w_pop_n = w_b;
         end else if ((w_count != '0) && ((r_state == ST_DRAIN) || !io_bus.lp_irdy)) begin
            w_emit  = 1'b1;
            w_pop_n = POP_W'(w_count);
         end
      end
   end

   always_comb begin
      w_pop_bytes = '0;
      w_tx_data   = '0;
      for (int unsigned t = 0; t < MAX_B; t++) begin
         w_pop_bytes[t] = (t < 32'(w_pop_n)) ? w_rd_data[8*t +: 8] : PAD_BYTE;
      end
      for (int unsigned l = 0; l < LANESNUMBER; l++) begin
         for (int unsigned t = 0; t < SLOTS; t++) begin
            if ((l < 32'(r_cfg.lanes)) && (t < 32'(r_cfg.wbytes))) begin
               w_tx_data[MAXPIPEWIDTH*l + 8*t +: 8] = w_pop_bytes[t*32'(r_cfg.lanes) + l];
            end
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_start)          w_state_next = ST_RUN;
         ST_RUN:   if (!i_enable)        w_state_next = ST_DRAIN;
         ST_DRAIN: if (w_count == '0)    w_state_next = ST_IDLE;
         default:                        w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_pclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= ST_IDLE;
         r_cfg      <= '0;
         r_err_cfg  <= 1'b0;
         r_tx_data  <= '0;
         r_tx_valid <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_start) begin
            r_cfg.lanes  <= i_cfg_lanes;
            r_cfg.wbytes <= width_bytes(i_cfg_width);
         end
         if ((r_state == ST_IDLE) && i_enable && !w_cfg_ok) begin
            r_err_cfg <= 1'b1;
         end
         r_tx_data  <= w_emit ? w_tx_data : '0;
         r_tx_valid <= w_emit ? w_lane_mask : '0;
      end
   end

   assign io_bus.TxData      = r_tx_data;
   assign io_bus.TxDataValid = r_tx_valid;
   assign o_busy             = (r_state != ST_IDLE);
   assign o_err_cfg          = r_err_cfg;

   a_valid_contiguous: assert property (@(posedge i_pclk) disable iff (!i_reset_n)
      (io_bus.lp_irdy && io_bus.pl_trdy) |->
      ((io_bus.lp_valid & (io_bus.lp_valid + LPIF_BYTES'(1))) == '0));

endmodule

// File: tb/tb_lpif_tx_lane_striper.sv
// Directed-vector bench for lpif_tx_lane_striper at default parameters (16 lanes, 32b, 64B LPIF).
module tb_lpif_tx_lane_striper;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic [4:0] cfg_lanes;
   logic [1:0] cfg_width;
   logic       busy;
   logic       err_cfg;
   int         n_vec;
   int         n_err;

   lpif_tx_lane_striper_if bus_if ();

   lpif_tx_lane_striper dut (
      .i_pclk      (clk),
      .i_reset_n   (rst_n),
      .i_enable    (enable),
      .i_cfg_lanes (cfg_lanes),
      .i_cfg_width (cfg_width),
      .io_bus      (bus_if),
      .o_busy      (busy),
      .o_err_cfg   (err_cfg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] tx_byte(input int unsigned l, input int unsigned t);
      return bus_if.TxData[32*l + 8*t +: 8];
   endfunction

   task automatic set_beat(input int unsigned base, input logic [63:0] valid);
      for (int unsigned i = 0; i < 64; i++) bus_if.lp_data[8*i +: 8] = 8'(base + i);
      bus_if.lp_valid = valid;
      bus_if.lp_irdy  = 1'b1;
   endtask

   task automatic wait_idle(input string tag);
      int unsigned k = 0;
      while (busy !== 1'b0 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL %s_idle: busy=%b want 0 after %0d cycles", tag, busy, k);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; cfg_lanes = 5'd0; cfg_width = 2'd0;
      bus_if.lp_irdy = 1'b0; bus_if.lp_data = '0; bus_if.lp_valid = '0;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({busy, err_cfg, bus_if.pl_trdy, bus_if.TxDataValid} !== 19'd0) begin
         n_err++;
         $display("FAIL reset_ctl: busy/err/trdy/valid=%b want 0",
                  {busy, err_cfg, bus_if.pl_trdy, bus_if.TxDataValid});
      end
      n_vec++;
      if (bus_if.TxData !== '0) begin
         n_err++;
         $display("FAIL reset_data: got %h want 0", bus_if.TxData);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if ({busy, bus_if.pl_trdy} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_release: busy/trdy=%b want 00", {busy, bus_if.pl_trdy});
      end
   endtask

   task automatic test_full_stripe();
      logic ok;
      enable = 1'b1; cfg_lanes = 5'd16; cfg_width = 2'd2;
      @(negedge clk);
      n_vec++;
      if (bus_if.pl_trdy !== 1'b1) begin
         n_err++;
         $display("FAIL t1_trdy: got %b want 1", bus_if.pl_trdy);
      end
      set_beat(0, '1);
      @(negedge clk);
      bus_if.lp_irdy = 1'b0;
      n_vec++;
      if (bus_if.TxDataValid !== 16'h0000) begin
         n_err++;
         $display("FAIL t1_early: valid=%h want 0000", bus_if.TxDataValid);
      end
      @(negedge clk);
      n_vec++;
      if (bus_if.TxDataValid !== 16'hFFFF) begin
         n_err++;
         $display("FAIL t1_valid: got %h want ffff", bus_if.TxDataValid);
      end
      ok = 1'b1;
      for (int unsigned l = 0; l < 16; l++)
         for (int unsigned t = 0; t < 4; t++)
            if (tx_byte(l, t) !== 8'(16*t + l)) ok = 1'b0;
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL t1_data: got %h want lane l slot t = 16t+l", bus_if.TxData);
      end
      @(negedge clk);
      n_vec++;
      if (bus_if.TxDataValid !== 16'h0000 || bus_if.TxData !== '0) begin
         n_err++;
         $display("FAIL t1_quiet: valid=%h data=%h want 0", bus_if.TxDataValid, bus_if.TxData);
      end
      enable = 1'b0;
      wait_idle("t1");
   endtask

   task automatic test_back_to_back();
      int unsigned sent = 0, exp_k = 0, drop_cyc = 0, back_cyc = 0, acc_at_drop = 0;
      bit dropped = 1'b0, back = 1'b0;
      logic [511:0] exp_d;
      enable = 1'b1; cfg_lanes = 5'd1; cfg_width = 2'd0;
      for (int unsigned cyc = 0; cyc < 800; cyc++) begin
         @(negedge clk);
         if (bus_if.TxDataValid !== 16'h0000) begin
            exp_d = '0;
            exp_d[7:0] = 8'(exp_k);
            n_vec++;
            if (bus_if.TxDataValid !== 16'h0001 || bus_if.TxData !== exp_d) begin
               n_err++;
               $display("FAIL t2_byte%0d: valid=%h lane0=%h want 0001/%h", exp_k,
                        bus_if.TxDataValid, bus_if.TxData[31:0], exp_d[31:0]);
            end
            exp_k++;
         end
         if (sent < 5) begin
            set_beat(64*sent, '1);
            if (bus_if.pl_trdy) begin
               sent++;
               if (dropped && !back) begin back = 1'b1; back_cyc = cyc; end
            end else if (!dropped) begin
               dropped = 1'b1; drop_cyc = cyc; acc_at_drop = sent;
            end
         end else begin
            bus_if.lp_irdy = 1'b0;
            enable = 1'b0;
            if (busy === 1'b0) break;
         end
      end
      n_vec++;
      if (!dropped || acc_at_drop != 4) begin
         n_err++;
         $display("FAIL t2_drop: beats before trdy drop=%0d want 4", acc_at_drop);
      end
      n_vec++;
      if (!back || (back_cyc - drop_cyc) != 61) begin
         n_err++;
         $display("FAIL t2_resume: trdy low for %0d cycles want 61", back_cyc - drop_cyc);
      end
      n_vec++;
      if (exp_k != 320) begin
         n_err++;
         $display("FAIL t2_total: emitted %0d bytes want 320", exp_k);
      end
      wait_idle("t2");
   endtask

   task automatic test_tail_pad();
      logic [511:0] exp_d;
      enable = 1'b1; cfg_lanes = 5'd4; cfg_width = 2'd1;
      @(negedge clk);
      set_beat(8'h10, 64'h1F);
      @(negedge clk);
      bus_if.lp_irdy = 1'b0;
      @(negedge clk);
      exp_d = '0;
      exp_d[7:0]   = 8'h10;
      exp_d[15:8]  = 8'h14;
      exp_d[39:32] = 8'h11;
      exp_d[71:64] = 8'h12;
      exp_d[103:96] = 8'h13;
      n_vec++;
      if (bus_if.TxDataValid !== 16'h000F) begin
         n_err++;
         $display("FAIL t3_valid: got %h want 000f", bus_if.TxDataValid);
      end
      n_vec++;
      if (bus_if.TxData !== exp_d) begin
         n_err++;
         $display("FAIL t3_data: got %h want %h", bus_if.TxData[127:0], exp_d[127:0]);
      end
      @(negedge clk);
      n_vec++;
      if (bus_if.TxDataValid !== 16'h0000) begin
         n_err++;
         $display("FAIL t3_single: valid=%h want 0000", bus_if.TxDataValid);
      end
      enable = 1'b0;
      wait_idle("t3");
   endtask

   task automatic test_drain();
      logic ok;
      int unsigned k;
      enable = 1'b1; cfg_lanes = 5'd8; cfg_width = 2'd2;
      @(negedge clk);
      set_beat(0, '1);
      @(negedge clk);
      n_vec++;
      if (bus_if.pl_trdy !== 1'b1) begin
         n_err++;
         $display("FAIL t5_trdy_run: got %b want 1", bus_if.pl_trdy);
      end
      set_beat(64, 64'h0000_000F_FFFF_FFFF);
      enable = 1'b0;
      for (int unsigned e = 0; e < 4; e++) begin
         @(negedge clk);
         bus_if.lp_irdy = 1'b0;
         n_vec++;
         if (bus_if.pl_trdy !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL t5_drain%0d: trdy=%b busy=%b want 0/1", e, bus_if.pl_trdy, busy);
         end
         n_vec++;
         if (bus_if.TxDataValid !== 16'h00FF) begin
            n_err++;
            $display("FAIL t5_valid%0d: got %h want 00ff", e, bus_if.TxDataValid);
         end
         ok = 1'b1;
         for (int unsigned l = 0; l < 16; l++)
            for (int unsigned t = 0; t < 4; t++) begin
               k = 32*e + 8*t + l;
               if (tx_byte(l, t) !== ((l < 8 && k < 100) ? 8'(k) : 8'h00)) ok = 1'b0;
            end
         n_vec++;
         if (!ok) begin
            n_err++;
            $display("FAIL t5_data%0d: got %h", e, bus_if.TxData[255:0]);
         end
      end
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || bus_if.TxDataValid !== 16'h0000) begin
         n_err++;
         $display("FAIL t5_end: busy=%b valid=%h want 0/0000", busy, bus_if.TxDataValid);
      end
      wait_idle("t5");
   endtask

   task automatic test_bad_cfg();
      enable = 1'b1; cfg_lanes = 5'd3; cfg_width = 2'd2;
      set_beat(0, '1);
      for (int unsigned i = 0; i < 6; i++) begin
         @(negedge clk);
         n_vec++;
         if ({err_cfg, busy, bus_if.pl_trdy} !== 3'b100) begin
            n_err++;
            $display("FAIL t4_lanes%0d: err/busy/trdy=%b want 100", i,
                     {err_cfg, busy, bus_if.pl_trdy});
         end
      end
      cfg_lanes = 5'd4; cfg_width = 2'd3;
      repeat (2) @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || bus_if.TxDataValid !== 16'h0000) begin
         n_err++;
         $display("FAIL t4_width: busy=%b valid=%h want 0", busy, bus_if.TxDataValid);
      end
      enable = 1'b0; bus_if.lp_irdy = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++;
      if (err_cfg !== 1'b1) begin
         n_err++;
         $display("FAIL t4_sticky: err_cfg=%b want 1", err_cfg);
      end
   endtask

   task automatic test_reset_midstream();
      logic [511:0] exp_d;
      enable = 1'b1; cfg_lanes = 5'd16; cfg_width = 2'd2;
      @(negedge clk);
      set_beat(0, '1);
      @(negedge clk);
      set_beat(64, '1);
      @(negedge clk);
      bus_if.lp_irdy = 1'b0;
      n_vec++;
      if (bus_if.TxDataValid !== 16'hFFFF) begin
         n_err++;
         $display("FAIL t6_live: valid=%h want ffff", bus_if.TxDataValid);
      end
      #1 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({busy, err_cfg, bus_if.pl_trdy, bus_if.TxDataValid} !== 19'd0 || bus_if.TxData !== '0)
      begin
         n_err++;
         $display("FAIL t6_async: busy/err/trdy/valid=%b data!=0:%b want 0",
                  {busy, err_cfg, bus_if.pl_trdy, bus_if.TxDataValid}, bus_if.TxData !== '0);
      end
      @(negedge clk);
      rst_n = 1'b1; enable = 1'b1; cfg_lanes = 5'd2; cfg_width = 2'd0;
      @(negedge clk);
      n_vec++;
      if ({busy, bus_if.pl_trdy} !== 2'b11) begin
         n_err++;
         $display("FAIL t6_restart: busy/trdy=%b want 11", {busy, bus_if.pl_trdy});
      end
      set_beat(8'hC0, '1);
      @(negedge clk);
      bus_if.lp_irdy = 1'b0;
      @(negedge clk);
      exp_d = '0;
      exp_d[7:0]   = 8'hC0;
      exp_d[39:32] = 8'hC1;
      n_vec++;
      if (bus_if.TxDataValid !== 16'h0003 || bus_if.TxData !== exp_d) begin
         n_err++;
         $display("FAIL t6_first: valid=%h data=%h want 0003/%h", bus_if.TxDataValid,
                  bus_if.TxData[63:0], exp_d[63:0]);
      end
      enable = 1'b0;
      wait_idle("t6");
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_full_stripe();
      test_back_to_back();
      test_tail_pad();
      test_drain();
      test_bad_cfg();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
